// File: rtl/mem_ctrl_pkg.sv
// Size codes, FSM encoding and byte lane helpers for the unified RAM-port controller.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] IO_BASE_HI_DEF = 2'b11;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    // The reserved size code is treated as a full word.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates ICache/LSB onto the 8-bit RAM port, one byte per cycle; a word completes 5 cycles after accept.
// Requests wait (no accept) while busy, during a completion pulse, or when a store targets a full IO buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         RAM_LAT    = 1,
    parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    output logic        icache_valid,
    output logic [31:0] icache_instr,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic        jump_wrong,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    mc_state_e   state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  nbytes_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic        is_ifetch_q;

    logic        icache_valid_q;
    logic [31:0] icache_instr_q;
    logic        lsb_done_q;
    logic [31:0] lsb_rdata_q;
    logic [7:0]  mem_dout_q;
    logic [31:0] mem_a_q;
    logic        mem_wr_q;

    logic        lsb_io_blocked;
    logic        lsb_ok;
    logic        ic_ok;
    logic        can_accept;
    logic        take_lsb;
    logic        take_ic;
    logic [2:0]  nbytes_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic        we_d;

    logic        flush;
    logic        sample;
    logic [1:0]  samp_idx;
    logic [31:0] rdata_d;
    logic        last;
    logic [2:0]  cnt_d;
    logic        issue_next;

    // A load or ifetch is held off by a flush; a store only by a full IO buffer.
    assign lsb_io_blocked = lsb_we && (lsb_addr[17:16] == IO_BASE_HI) && io_buffer_full;
    assign lsb_ok         = lsb_req && (lsb_we ? !lsb_io_blocked : !jump_wrong);
    assign ic_ok          = icache_req && !jump_wrong;
    assign can_accept     = (state_q == MC_IDLE) && !icache_valid_q && !lsb_done_q;
    assign take_lsb       = can_accept && lsb_ok;
    assign take_ic        = can_accept && !lsb_ok && ic_ok;

    assign nbytes_d = take_lsb ? size_to_nbytes(lsb_size) : 3'd4;
    assign addr_d   = take_lsb ? lsb_addr : icache_addr;
    assign wdata_d  = take_lsb ? lsb_wdata : 32'h0;
    assign we_d     = take_lsb && lsb_we;

    // cnt_q is the index of the byte currently on the bus; read data trails it by LAT.
    assign flush      = !we_q && jump_wrong;
    assign sample     = cnt_q >= LAT;
    assign samp_idx   = 2'(cnt_q - LAT);
    assign rdata_d    = sample ? put_byte(rdata_q, samp_idx, mem_din) : rdata_q;
    assign last       = cnt_q == 3'(nbytes_q + LAT - 3'd1);
    assign cnt_d      = cnt_q + 3'd1;
    assign issue_next = cnt_d < nbytes_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= MC_IDLE;
            cnt_q          <= 3'd0;
            nbytes_q       <= 3'd0;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            rdata_q        <= 32'h0;
            we_q           <= 1'b0;
            is_ifetch_q    <= 1'b0;
            icache_valid_q <= 1'b0;
            icache_instr_q <= 32'h0;
            lsb_done_q     <= 1'b0;
            lsb_rdata_q    <= 32'h0;
            mem_dout_q     <= 8'h0;
            mem_a_q        <= 32'h0;
            mem_wr_q       <= 1'b0;
        end else if (rdy) begin
            icache_valid_q <= 1'b0;
            lsb_done_q     <= 1'b0;
            case (state_q)
                MC_IDLE: begin
                    if (take_lsb || take_ic) begin
                        state_q     <= MC_BUSY;
                        cnt_q       <= 3'd0;
                        nbytes_q    <= nbytes_d;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        rdata_q     <= 32'h0;
                        we_q        <= we_d;
                        is_ifetch_q <= take_ic;
                        mem_a_q     <= addr_d;
                        mem_wr_q    <= we_d;
                        mem_dout_q  <= wdata_d[7:0];
                    end
                end
                MC_BUSY: begin
                    if (flush || last) begin
                        state_q    <= MC_IDLE;
                        cnt_q      <= 3'd0;
                        mem_a_q    <= 32'h0;
                        mem_wr_q   <= 1'b0;
                        mem_dout_q <= 8'h0;
                        if (!flush) begin
                            if (is_ifetch_q) begin
                                icache_valid_q <= 1'b1;
                                icache_instr_q <= rdata_d;
                            end else begin
                                lsb_done_q <= 1'b1;
                                if (!we_q) begin
                                    lsb_rdata_q <= rdata_d;
                                end
                            end
                        end
                    end else begin
                        cnt_q   <= cnt_d;
                        rdata_q <= rdata_d;
                        if (issue_next) begin
                            mem_a_q    <= addr_q + {29'd0, cnt_d};
                            mem_wr_q   <= we_q;
                            mem_dout_q <= get_byte(wdata_q, cnt_d[1:0]);
                        end else begin
                            mem_a_q    <= 32'h0;
                            mem_wr_q   <= 1'b0;
                            mem_dout_q <= 8'h0;
                        end
                    end
                end
            endcase
        end
    end

    assign icache_valid = icache_valid_q;
    assign icache_instr = icache_instr_q;
    assign lsb_done     = lsb_done_q;
    assign lsb_rdata    = lsb_rdata_q;
    assign mem_dout     = mem_dout_q;
    assign mem_a        = mem_a_q;
    assign mem_wr       = mem_wr_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits between the 8-bit unified RAM port and the two 32-bit memory clients: the ICache, which issues instruction refills, and the load/store buffer (LSB).
- Arbitrates one request at a time.
- Serialises each word, half or byte access into per-byte RAM cycles.
- Reassembles read data little-endian and returns it with a one-cycle valid/done pulse.

Parameters:
- RAM_LAT, 1, RAM read latency in cycles (address in cycle t, data on mem_din in cycle t+1); only 1 is supported.
- IO_BASE_HI, 2'b11, value of addr[17:16] that marks an IO-mapped address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- rdy  in  1  global enable; when low, every register holds its value
- icache_req  in  1  ICache needs the word at icache_addr
- icache_addr  in  32  refill address, word-aligned
- icache_valid  out  1  one-cycle pulse; icache_instr is valid
- icache_instr  out  32  assembled instruction word
- lsb_req  in  1  LSB access request
- lsb_we  in  1  1 = store, 0 = load
- lsb_size  in  2  0 = byte, 1 = half, 2 = word
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data, low bytes used
- lsb_done  out  1  one-cycle pulse; access complete
- lsb_rdata  out  32  load data, zero-extended
- jump_wrong  in  1  misprediction flush
- io_buffer_full  in  1  IO output buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, byte counter 0, all outputs 0. A reset mid-access abandons the access; no valid/done is produced.
- States and transitions:
  - IDLE -> BUSY on accept.
  - BUSY -> IDLE at the edge that samples or issues the last byte.
  - Valid/done is registered on that same edge.
- Accept happens only in IDLE and only with rdy=1.
  - No accept in a cycle where icache_valid or lsb_done is high; the requester drops req during that cycle.
  - Priority: LSB over ICache when both request.
  - ICache and load requests are not accepted when jump_wrong=1.
  - A store with lsb_addr[17:16]==IO_BASE_HI is not accepted while io_buffer_full=1.
- Accepted request latches addr, we, and N bytes (word = 4, half = 2, byte = 1; ICache always 4).
- Timing, with accept edge = E0:
  - Cycle k+1 (k = 0..N-1): mem_a = addr+k (32-bit wrap), mem_wr = we, mem_dout = wdata[8k+7:8k].
  - Read byte k is sampled from mem_din at E(k+2) into bits [8k+7:8k].
  - Valid/done rises at E(N+1) and lasts one cycle, so a word access completes 5 cycles after accept. icache_instr/lsb_rdata hold until the next completion.
- Stores use the same timing. mem_wr is 1 for exactly cycles 1..N. Reads drive mem_wr=0.
- Idle bus: mem_a=0, mem_wr=0, mem_dout=0.
- jump_wrong during a BUSY ifetch or load: return to IDLE at the next edge, no valid/done, bus idle. Bytes already read are discarded.
- jump_wrong during a BUSY store: ignored; the store completes and pulses lsb_done.
- rdy=0 mid-access: everything freezes, including the byte counter and bus outputs, and resumes when rdy returns to 1.
- Unused upper lsb_rdata bytes are 0. Sign extension is the LSB's job.

Decomposition:
- Add to op_map.v: size codes (`SIZE_B/`SIZE_H/`SIZE_W), state encodings (`MC_IDLE/`MC_BUSY), `IO_BASE_HI.
- No sub-module is needed. Byte select and assembly are small enough to stay inline.

Test Plan:
- ICache req at 0x1000, RAM bytes 13 05 00 00:
  - mem_a 0x1000..0x1003 in cycles 1-4, mem_wr=0.
  - icache_valid pulses at E5 with icache_instr=0x00000513.
- LSB half store 0xBEEF to 0x2002:
  - cycle 1: mem_a=0x2002, mem_dout=EF, mem_wr=1.
  - cycle 2: mem_a=0x2003, mem_dout=BE, mem_wr=1.
  - lsb_done at E3.
  - byte load of 0x2003 returns lsb_rdata=0x000000BE.
- icache_req and lsb_req (word load 0x3000) both asserted at E0:
  - LSB served first, lsb_done at E5.
  - ifetch accepted at E7 (E6 blocked by the done cycle), icache_valid at E12.
- jump_wrong in cycle 3 of an ifetch:
  - IDLE at E3, mem_a=0, no icache_valid.
  - Same flush during a word store: all 4 writes occur, lsb_done at E5.
- Byte store to 0x30000 with io_buffer_full=1 for 3 cycles:
  - no mem_wr while full.
  - accepted at the first edge with full=0, single write, then done.
- rst=0 at E2 of a word load:
  - all outputs 0 next cycle, no lsb_done.
  - a new request after reset completes normally.
